digit_scan_ctrl: RTL and testbench

Upstream sequencer for the dual 4-to-1 multiplexer stage in the digital clock display path. It generates the mux select lines (a1, a0) and the active-low strobes (s1_n, s2_n) that pick one of four BCD digits, plus the matching active-low digit anode drives for a 4-digit multiplexed 7-segment display. It inserts a blanking interval at the start of every digit slot so the mux output settles before the anode turns on, which suppresses ghosting.

---
 rtl/display_scan_pkg.sv | 19 +
 rtl/digit_scan_ctrl_if.sv | 25 ++
 rtl/digit_scan_ctrl_slot_prescaler.sv | 36 +++
 rtl/digit_scan_ctrl.sv | 75 +++++++
 tb/tb_digit_scan_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/display_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scan path.
// Used by the scan controller and its interface.
package display_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = 2;

   localparam logic [NUM_DIGITS-1:0] AN_BLANK = 4'b1111;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   // Active-low anode pattern with only the selected digit pulled low.
   function automatic logic [NUM_DIGITS-1:0] onehot_n(input logic [IDX_W-1:0] idx);
      logic [NUM_DIGITS-1:0] pat;
      pat      = AN_BLANK;
      pat[idx] = 1'b0;
      return pat;
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Scan-control bundle between the display sequencer and its host.
// master = host side (drives enable/mask), slave = the scan controller.
interface digit_scan_if;
   import display_scan_pkg::*;

   logic                  en;
   logic [NUM_DIGITS-1:0] digit_mask;
   logic                  a1;
   logic                  a0;
   logic                  s1_n;
   logic                  s2_n;
   logic [NUM_DIGITS-1:0] an_n;
   logic                  frame_tick;

   modport master (
      output en, digit_mask,
      input  a1, a0, s1_n, s2_n, an_n, frame_tick
   );

   modport slave (
      input  en, digit_mask,
      output a1, a0, s1_n, s2_n, an_n, frame_tick
   );

endinterface

// File: rtl/digit_scan_ctrl_slot_prescaler.sv
// Enabled modulo-DIV counter with terminal-count flag; reusable for any
// divided clock-enable. cnt_next is exported so callers can register from it.
module slot_prescaler #(
   parameter  int DIV = 1000,
   localparam int W   = $clog2(DIV)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_next,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(DIV - 1);

   assign tc = (cnt == LAST);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_next = cnt;
      if (en) begin
         cnt_next = tc ? '0 : cnt + 1'b1;
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan sequencer: steps the BCD mux selects across four digits and drives
// strobes/anodes with a blanking window at the start of every slot.
module digit_scan_ctrl
   import display_scan_pkg::*;
#(
   parameter int CLK_DIV      = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic      clk,
   input  logic      rst,
   digit_scan_if.slave bus
);

   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic                  tc;
   logic                  slot_end;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_next;
   logic [NUM_DIGITS-1:0] mask_q;
   logic [NUM_DIGITS-1:0] mask_next;
   logic                  active_next;
   logic                  strobe_n_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  frame_tick_q;

   slot_prescaler #(.DIV(CLK_DIV)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .cnt      (cnt),
      .cnt_next (cnt_next),
      .tc       (tc)
   );

   assign slot_end = bus.en & tc;

   // Outputs are registered from next-state values so they line up with the
   // state they describe without an extra cycle of lag.
   always_comb begin
      idx_next  = idx;
      mask_next = mask_q;
      if (slot_end) begin
         idx_next  = idx + 1'b1;
         mask_next = bus.digit_mask;
      end
      active_next = bus.en && (int'(cnt_next) >= BLANK_CYCLES) && mask_next[idx_next];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= '0;
         mask_q       <= '0;
         strobe_n_q   <= 1'b1;
         an_q         <= AN_BLANK;
         frame_tick_q <= 1'b0;
      end else begin
         idx          <= idx_next;
         mask_q       <= mask_next;
         strobe_n_q   <= ~active_next;
         an_q         <= active_next ? onehot_n(idx_next) : AN_BLANK;
         frame_tick_q <= slot_end && (idx == LAST_IDX);
      end
   end

   assign bus.a1         = idx[1];
   assign bus.a0         = idx[0];
   assign bus.s1_n       = strobe_n_q;
   assign bus.s2_n       = strobe_n_q;
   assign bus.an_n       = an_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: a CLK_DIV=8/BLANK=2 instance driven from a
// vector table, plus a BLANK=0 instance exercised by a hand-written sequence.
module tb_digit_scan_ctrl;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   digit_scan_if bus_a ();
   digit_scan_if bus_b ();

   digit_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   digit_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(0)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   // One table row: inputs held for n edges, then the expected outputs.
   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] mask;
      int         n;
      logic [1:0] sel;
      logic       s_n;
      logic [3:0] an;
      logic       ft;
   } vec_t;

   localparam int NV = 33;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got {sel,s1_n,s2_n,an_n,ft}=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [8:0] snap_a();
      return {bus_a.a1, bus_a.a0, bus_a.s1_n, bus_a.s2_n, bus_a.an_n, bus_a.frame_tick};
   endfunction

   function automatic logic [8:0] snap_b();
      return {bus_b.a1, bus_b.a0, bus_b.s1_n, bus_b.s2_n, bus_b.an_n, bus_b.frame_tick};
   endfunction

   function automatic logic [8:0] expect_out(input logic [1:0] sel, input logic s_n,
                                             input logic [3:0] an, input logic ft);
      return {sel, s_n, s_n, an, ft};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int ticks;
   int actives;

   initial begin
      // k = edges since reset release, cnt = k%8, idx = (k/8)%4
      //              rst   en    mask     n   sel    s_n   an       ft
      vecs[0]  = '{1'b1, 1'b1, 4'b1111,  1, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 4'b1111,  2, 2'd0, 1'b1, 4'b1111, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'b1111,  1, 2'd0, 1'b1, 4'b1111, 1'b0}; // k=1
      vecs[3]  = '{1'b0, 1'b1, 4'b1111,  6, 2'd0, 1'b1, 4'b1111, 1'b0}; // k=7 slot0 blank
      vecs[4]  = '{1'b0, 1'b1, 4'b1111,  1, 2'd1, 1'b1, 4'b1111, 1'b0}; // k=8
      vecs[5]  = '{1'b0, 1'b1, 4'b1111,  1, 2'd1, 1'b1, 4'b1111, 1'b0}; // k=9
      vecs[6]  = '{1'b0, 1'b1, 4'b1111,  1, 2'd1, 1'b0, 4'b1101, 1'b0}; // k=10
      vecs[7]  = '{1'b0, 1'b1, 4'b1111,  5, 2'd1, 1'b0, 4'b1101, 1'b0}; // k=15
      vecs[8]  = '{1'b0, 1'b1, 4'b1111,  1, 2'd2, 1'b1, 4'b1111, 1'b0}; // k=16
      vecs[9]  = '{1'b0, 1'b1, 4'b1111,  2, 2'd2, 1'b0, 4'b1011, 1'b0}; // k=18
      vecs[10] = '{1'b0, 1'b1, 4'b1111,  8, 2'd3, 1'b0, 4'b0111, 1'b0}; // k=26
      vecs[11] = '{1'b0, 1'b1, 4'b1111,  5, 2'd3, 1'b0, 4'b0111, 1'b0}; // k=31
      vecs[12] = '{1'b0, 1'b1, 4'b1111,  1, 2'd0, 1'b1, 4'b1111, 1'b1}; // k=32 wrap
      vecs[13] = '{1'b0, 1'b1, 4'b1111,  1, 2'd0, 1'b1, 4'b1111, 1'b0}; // k=33
      vecs[14] = '{1'b0, 1'b1, 4'b1111,  1, 2'd0, 1'b0, 4'b1110, 1'b0}; // k=34
      vecs[15] = '{1'b0, 1'b1, 4'b0101,  8, 2'd1, 1'b1, 4'b1111, 1'b0}; // k=42 masked
      vecs[16] = '{1'b0, 1'b1, 4'b0101,  5, 2'd1, 1'b1, 4'b1111, 1'b0}; // k=47
      vecs[17] = '{1'b0, 1'b1, 4'b0101,  3, 2'd2, 1'b0, 4'b1011, 1'b0}; // k=50
      vecs[18] = '{1'b0, 1'b1, 4'b0101,  8, 2'd3, 1'b1, 4'b1111, 1'b0}; // k=58 masked
      vecs[19] = '{1'b0, 1'b1, 4'b0101,  6, 2'd0, 1'b1, 4'b1111, 1'b1}; // k=64 wrap
      vecs[20] = '{1'b0, 1'b1, 4'b0101,  2, 2'd0, 1'b0, 4'b1110, 1'b0}; // k=66
      vecs[21] = '{1'b0, 1'b1, 4'b0101, 19, 2'd2, 1'b0, 4'b1011, 1'b0}; // k=85 slot2 cnt5
      vecs[22] = '{1'b0, 1'b0, 4'b0101,  1, 2'd2, 1'b1, 4'b1111, 1'b0}; // en low, frozen
      vecs[23] = '{1'b0, 1'b0, 4'b0101,  3, 2'd2, 1'b1, 4'b1111, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 4'b0101,  0, 2'd2, 1'b1, 4'b1111, 1'b0}; // en back, still blank
      vecs[25] = '{1'b0, 1'b1, 4'b0101,  1, 2'd2, 1'b0, 4'b1011, 1'b0}; // cnt6
      vecs[26] = '{1'b0, 1'b1, 4'b0101,  1, 2'd2, 1'b0, 4'b1011, 1'b0}; // cnt7
      vecs[27] = '{1'b0, 1'b1, 4'b0101,  1, 2'd3, 1'b1, 4'b1111, 1'b0}; // slot3 cnt0
      vecs[28] = '{1'b0, 1'b1, 4'b0101, 28, 2'd2, 1'b0, 4'b1011, 1'b0}; // slot2 cnt4
      vecs[29] = '{1'b1, 1'b1, 4'b0101,  1, 2'd0, 1'b1, 4'b1111, 1'b0}; // mid-slot reset
      vecs[30] = '{1'b0, 1'b1, 4'b0101,  1, 2'd0, 1'b1, 4'b1111, 1'b0}; // cnt1
      vecs[31] = '{1'b0, 1'b1, 4'b0101,  6, 2'd0, 1'b1, 4'b1111, 1'b0}; // cnt7 blank
      vecs[32] = '{1'b0, 1'b1, 4'b0101,  3, 2'd1, 1'b1, 4'b1111, 1'b0}; // slot1 masked

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.en = 1'b1;
      bus_a.digit_mask = 4'b1111;
      bus_b.en = 1'b1;
      bus_b.digit_mask = 4'b1111;
      #1;

      for (int i = 0; i < NV; i++) begin
         rst_a            = vecs[i].rst;
         bus_a.en         = vecs[i].en;
         bus_a.digit_mask = vecs[i].mask;
         if (vecs[i].n == 0) #1;
         else step(vecs[i].n);
         check($sformatf("vec%0d", i), snap_a(),
               expect_out(vecs[i].sel, vecs[i].s_n, vecs[i].an, vecs[i].ft));
      end

      // BLANK_CYCLES=0 instance: mid-slot mask change and all-zero mask.
      step(1);
      check("b_reset", snap_b(), expect_out(2'd0, 1'b1, 4'b1111, 1'b0));
      rst_b = 1'b0;
      step(8);
      check("b_slot1_cnt0", snap_b(), expect_out(2'd1, 1'b0, 4'b1101, 1'b0));
      step(3);
      bus_b.digit_mask = 4'b0000;
      check("b_slot1_cnt3", snap_b(), expect_out(2'd1, 1'b0, 4'b1101, 1'b0));
      step(4);
      check("b_slot1_cnt7", snap_b(), expect_out(2'd1, 1'b0, 4'b1101, 1'b0));
      step(1);
      check("b_slot2_blank", snap_b(), expect_out(2'd2, 1'b1, 4'b1111, 1'b0));
      step(16);
      check("b_wrap_blank", snap_b(), expect_out(2'd0, 1'b1, 4'b1111, 1'b1));

      ticks   = 0;
      actives = 0;
      for (int c = 0; c < 64; c++) begin
         step(1);
         if (bus_b.frame_tick) ticks++;
         if (!bus_b.s1_n || !bus_b.s2_n || bus_b.an_n != 4'b1111) actives++;
      end
      check_int("b_zero_mask_ticks", ticks, 2);
      check_int("b_zero_mask_active", actives, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
